// File: rtl/dht11_controller_pkg.sv
// Shared definitions for the DHT11 reader: state encoding, frame geometry, timing helpers
// and the frame checksum function.
package dht11_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_WAIT      = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_SYNC      = 4'd5,
        ST_DATA      = 4'd6,
        ST_STOP      = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    localparam int FRAME_BITS = 40;
    localparam int SYNC_US    = 30;
    localparam int US_CNT_W   = 16;
    localparam int BIT_CNT_W  = 6;

    function automatic int us_divisor(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

    // Checksum byte must equal the 8-bit wrapped sum of the four data bytes.
    function automatic logic checksum_ok(input logic [39:0] frame);
        logic [7:0] sum_s;
        sum_s = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return (sum_s == frame[7:0]);
    endfunction

endpackage

// File: rtl/dht11_controller_tick_gen_us.sv
// Free-running 1 us strobe derived from CLK_HZ; one-cycle pulse every CLK_HZ/1e6 clocks.
module tick_gen_us
    import dht11_controller_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int DIV   = us_divisor(CLK_HZ);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Divider counter and registered strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_ONE;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/dht11_controller.sv
// DHT11 single-wire reader: host start condition, 40-bit frame decode, {humidity, temp} output.
// Define DHT11_CHECKSUM_EN to reject frames whose checksum byte does not match.
module dht11_controller
    import dht11_controller_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int START_LOW_US = 18_000,
    parameter int BIT1_TH_US   = 40,
    parameter int TIMEOUT_US   = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    inout  wire         dht11_io,
    output logic [15:0] dht11_data,
    output logic        dht11_valid,
    output logic        dht11_error,
    output logic        busy
);
    localparam logic [US_CNT_W-1:0]  START_LIM  = US_CNT_W'(START_LOW_US);
    localparam logic [US_CNT_W-1:0]  SYNC_LIM   = US_CNT_W'(SYNC_US);
    localparam logic [US_CNT_W-1:0]  TH_LIM     = US_CNT_W'(BIT1_TH_US);
    localparam logic [US_CNT_W-1:0]  TO_LIM     = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0]  US_ONE     = US_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE    = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] FRAME_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    state_t                  state_r, next_state_s;
    logic [1:0]              sync_r;
    logic                    line_d_r, line_s, rise_s, fall_s;
    logic                    tick_s, timeout_s, sensor_phase_s, state_change_s, accept_s;
    logic [US_CNT_W-1:0]     us_cnt_r, high_us_s;
    logic                    bit_val_s, seen_low_r, drive_low_r;
    logic [BIT_CNT_W-1:0]    bit_cnt_r;
    logic [FRAME_BITS-1:0]   frame_r;
    logic                    chk_match_s, done_ok_s, fail_s;
    logic [15:0]             data_r;
    logic                    valid_r, error_r, busy_r;

    tick_gen_us #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign dht11_io = drive_low_r ? 1'b0 : 1'bz;

    assign line_s         = sync_r[1];
    assign rise_s         = line_s & ~line_d_r;
    assign fall_s         = ~line_s & line_d_r;
    // Include the tick landing on the edge cycle so the measured width is phase-independent.
    assign high_us_s      = us_cnt_r + {{(US_CNT_W-1){1'b0}}, tick_s};
    assign bit_val_s      = (high_us_s > TH_LIM);
    assign timeout_s      = (us_cnt_r == TO_LIM);
    assign sensor_phase_s = state_r inside {ST_RESP_LOW, ST_RESP_HIGH, ST_SYNC, ST_DATA, ST_STOP};
    assign accept_s       = (state_r == ST_IDLE) && start;
    assign state_change_s = (next_state_s != state_r);
    assign chk_match_s    = checksum_ok(frame_r);
`ifdef DHT11_CHECKSUM_EN
    assign done_ok_s      = chk_match_s;
`else
    // Checksum byte is ignored in this build: every complete frame is accepted.
    assign done_ok_s      = chk_match_s | 1'b1;
`endif
    assign fail_s         = (sensor_phase_s && timeout_s) || ((state_r == ST_DONE) && !done_ok_s);

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:      if (start) next_state_s = ST_START;
                          else       next_state_s = ST_IDLE;
            ST_START:     if (us_cnt_r == START_LIM) next_state_s = ST_WAIT;
                          else                       next_state_s = ST_START;
            ST_WAIT:      if (us_cnt_r == SYNC_LIM) next_state_s = ST_RESP_LOW;
                          else                      next_state_s = ST_WAIT;
            ST_RESP_LOW:  if (timeout_s)                  next_state_s = ST_IDLE;
                          else if (seen_low_r && rise_s)  next_state_s = ST_RESP_HIGH;
                          else                            next_state_s = ST_RESP_LOW;
            ST_RESP_HIGH: if (timeout_s)   next_state_s = ST_IDLE;
                          else if (fall_s) next_state_s = ST_SYNC;
                          else             next_state_s = ST_RESP_HIGH;
            ST_SYNC:      if (timeout_s)   next_state_s = ST_IDLE;
                          else if (rise_s) next_state_s = ST_DATA;
                          else             next_state_s = ST_SYNC;
            ST_DATA:      if (timeout_s)                      next_state_s = ST_IDLE;
                          else if (fall_s && (bit_cnt_r == FRAME_LAST)) next_state_s = ST_STOP;
                          else if (fall_s)                    next_state_s = ST_SYNC;
                          else                                next_state_s = ST_DATA;
            ST_STOP:      if (timeout_s)   next_state_s = ST_IDLE;
                          else if (line_s) next_state_s = ST_DONE;
                          else             next_state_s = ST_STOP;
            ST_DONE:      next_state_s = ST_IDLE;
            default:      next_state_s = ST_IDLE;
        endcase
    end

    // Two-flop line synchronizer plus previous-sample flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r   <= 2'b11;
            line_d_r <= 1'b1;
        end else begin
            sync_r   <= {sync_r[0], dht11_io};
            line_d_r <= sync_r[1];
        end
    end

    // State register, per-state microsecond counter and response-low flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            us_cnt_r   <= '0;
            seen_low_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_change_s) begin
                us_cnt_r   <= '0;
                seen_low_r <= 1'b0;
            end else begin
                if (tick_s && (state_r != ST_IDLE)) us_cnt_r <= us_cnt_r + US_ONE;
                if ((state_r == ST_RESP_LOW) && !line_s) seen_low_r <= 1'b1;
            end
        end
    end

    // Frame shift register, filled MSB-first on each data-bit falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_r   <= '0;
            bit_cnt_r <= '0;
        end else if (accept_s) begin
            frame_r   <= '0;
            bit_cnt_r <= '0;
        end else if ((state_r == ST_DATA) && fall_s && !timeout_s) begin
            frame_r   <= {frame_r[FRAME_BITS-2:0], bit_val_s};
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
        end
    end

    // Registered outputs and line drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r      <= 16'h0000;
            valid_r     <= 1'b0;
            error_r     <= 1'b0;
            busy_r      <= 1'b0;
            drive_low_r <= 1'b0;
        end else begin
            if ((state_r == ST_DONE) && done_ok_s) data_r <= {frame_r[39:32], frame_r[23:16]};
            valid_r     <= (state_r == ST_DONE) && done_ok_s;
            if (accept_s)    error_r <= 1'b0;
            else if (fail_s) error_r <= 1'b1;
            busy_r      <= (next_state_s != ST_IDLE);
            drive_low_r <= (next_state_s == ST_START);
        end
    end

    assign dht11_data  = data_r;
    assign dht11_valid = valid_r;
    assign dht11_error = error_r;
    assign busy        = busy_r;

endmodule
